// File: rtl/id_scoreboard.sv
// ---------------------------------------------------------------------------
// id_scoreboard
//
// Register-dependency scoreboard and issue controller for the decode stage.
// It keeps one pending-write countdown (plus a load-producer flag) per
// architectural register. Each cycle it decides combinationally whether the
// decode instruction may issue or must stall on a source still being written.
//
// Optional feature macro: SCB_FORWARD_EN
//   undefined : full interlock, a source stalls while its countdown is nonzero.
//   defined   : bypass paths exist, only a load result consumed in the very
//               next cycle stalls (exactly one bubble).
//
// Ports
//   clk         : rising-edge clock
//   rst         : asynchronous reset, active low
//   enable      : stage enable; low blocks issue/stall, counters still drain
//   dec_valid   : decode holds a valid instruction
//   rs1_addr/rs2_addr, rs1_used/rs2_used : source registers and read flags
//   rd_addr, rd_we, rd_is_load : destination, write flag, load producer flag
//   flush       : discard all in-flight tracking (wins over an issue)
//   issue/stall : combinational issue / hold decisions
//   busy_mask   : bit i set while register i has a nonzero countdown
//   stall_cnt   : saturating count of stall cycles
// ---------------------------------------------------------------------------
module id_scoreboard #(
  parameter int NREGS  = 8,
  parameter int WB_LAT = 3,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             dec_valid,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_we,
  input  logic             rd_is_load,
  input  logic             flush,
  output logic             issue,
  output logic             stall,
  output logic [NREGS-1:0] busy_mask,
  output logic [15:0]      stall_cnt
);

  localparam int            CW  = $clog2(WB_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(WB_LAT);

  logic [CW-1:0]    cnt [NREGS];
  logic [NREGS-1:0] ld;
  logic [NREGS-1:0] hz_vec;
  logic             hazard;
  logic             gate;

  // Per-register hazard and busy decode.
  // NOTE: every output of this block gets a value on every pass, so no latch
  // can be inferred.
  always_comb begin
    hz_vec    = '0;
    busy_mask = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_mask[i] = (cnt[i] != '0);
`ifdef SCB_FORWARD_EN
      // Only a load result is late: it is unavailable for the single cycle
      // right after the load issued, when its countdown is still full.
      hz_vec[i] = ld[i] && (cnt[i] == LAT);
`else
      hz_vec[i] = (cnt[i] != '0);
`endif
    end
  end

  assign hazard = (rs1_used & hz_vec[rs1_addr]) | (rs2_used & hz_vec[rs2_addr]);
  // Reset is folded in so issue/stall drop immediately while rst is low.
  assign gate   = rst & enable & dec_valid & ~flush;
  assign issue  = gate & ~hazard;
  assign stall  = gate & hazard;

  // Countdown and load-flag state.
  // NOTE: the per-register counters are plain flops, not a RAM, so each one
  // is cleared by the asynchronous reset; a stale countdown after reset would
  // falsely stall the first instructions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt[i] <= '0;
      end
      ld <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREGS; i++) begin
        cnt[i] <= '0;
      end
      ld <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (issue && rd_we && (rd_addr == AW'(i))) begin
          // A new writer overwrites any pending one: the later write wins.
          cnt[i] <= LAT;
          ld[i]  <= rd_is_load;
        end else if (cnt[i] != '0) begin
          // NOTE: non-blocking updates, so every register sees the pre-edge
          // values of cnt/ld regardless of loop order.
          cnt[i] <= cnt[i] - 1'b1;
          if (cnt[i] == CW'(1)) begin
            ld[i] <= 1'b0;
          end
        end else begin
          ld[i] <= 1'b0;
        end
      end
    end
  end

  // Stall statistic, untouched by flush, sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_id_scoreboard
//
// Self-checking bench for id_scoreboard. The reference model keeps, per
// register, the cycle number of its last issued writer; a register is busy
// while fewer than WB_LAT+1 cycles have passed since then. A second instance
// with a long write-back latency drives the stall counter into saturation.
// ---------------------------------------------------------------------------
module tb_id_scoreboard;

  localparam int NREGS   = 8;
  localparam int WB_LAT  = 3;
  localparam int AW      = $clog2(NREGS);
  localparam int SAT_LAT = 15;

`ifdef SCB_FORWARD_EN
  localparam int RAW_STALLS = 0;
`else
  localparam int RAW_STALLS = WB_LAT;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals
  logic             rst, enable, dec_valid, rs1_used, rs2_used, rd_we, rd_is_load, flush;
  logic [AW-1:0]    rs1_addr, rs2_addr, rd_addr;
  logic             issue, stall;
  logic [NREGS-1:0] busy_mask;
  logic [15:0]      stall_cnt;

  // Saturation instance signals
  logic             s_rst, s_enable, s_dv, s_rd_we, s_ld;
  logic [AW-1:0]    s_rs1, s_rs2, s_rd;
  logic             s_issue, s_stall;
  logic [NREGS-1:0] s_busy;
  logic [15:0]      s_stall_cnt;

  id_scoreboard #(.NREGS(NREGS), .WB_LAT(WB_LAT)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .dec_valid(dec_valid),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rd_addr(rd_addr), .rd_we(rd_we), .rd_is_load(rd_is_load), .flush(flush),
    .issue(issue), .stall(stall), .busy_mask(busy_mask), .stall_cnt(stall_cnt)
  );

  id_scoreboard #(.NREGS(NREGS), .WB_LAT(SAT_LAT)) u_sat (
    .clk(clk), .rst(s_rst), .enable(s_enable), .dec_valid(s_dv),
    .rs1_addr(s_rs1), .rs2_addr(s_rs2), .rs1_used(1'b1), .rs2_used(1'b0),
    .rd_addr(s_rd), .rd_we(s_rd_we), .rd_is_load(s_ld), .flush(1'b0),
    .issue(s_issue), .stall(s_stall), .busy_mask(s_busy), .stall_cnt(s_stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [NREGS];
  bit          m_ld    [NREGS];
  int unsigned m_last  [NREGS];
  int unsigned now;
  int unsigned m_sc;

  function automatic bit m_busy(input int r);
    return m_valid[r] && ((now - m_last[r]) <= WB_LAT);
  endfunction

  function automatic bit m_hz(input int r);
`ifdef SCB_FORWARD_EN
    return m_valid[r] && m_ld[r] && ((now - m_last[r]) == 1);
`else
    return m_busy(r);
`endif
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_valid[i] = 1'b0;
      m_ld[i]    = 1'b0;
    end
  endtask

  task automatic set_instr(input int dv, input int r1, input int u1, input int r2,
                           input int u2, input int rd, input int we, input int ldf);
    dec_valid  = 1'(dv);
    rs1_addr   = AW'(r1);
    rs1_used   = 1'(u1);
    rs2_addr   = AW'(r2);
    rs2_used   = 1'(u2);
    rd_addr    = AW'(rd);
    rd_we      = 1'(we);
    rd_is_load = 1'(ldf);
  endtask

  // One cycle: entered at posedge+1 with inputs driven; checks at the falling
  // edge, advances the model at the rising edge, returns at posedge+1.
  task automatic step();
    bit               haz, gate, e_issue, e_stall;
    logic [NREGS-1:0] e_busy;
    if (!rst) begin
      m_clear();
      m_sc = 0;
    end
    #4;
    haz     = (rs1_used && m_hz(int'(rs1_addr))) || (rs2_used && m_hz(int'(rs2_addr)));
    gate    = rst && enable && dec_valid && !flush;
    e_issue = gate && !haz;
    e_stall = gate && haz;
    for (int i = 0; i < NREGS; i++) e_busy[i] = m_busy(i);
    check("issue", 32'(issue), 32'(e_issue));
    check("stall", 32'(stall), 32'(e_stall));
    check("busy_mask", 32'(busy_mask), 32'(e_busy));
    check("stall_cnt", 32'(stall_cnt), m_sc);
    @(posedge clk);
    if (rst) begin
      if (flush) begin
        m_clear();
      end else if (e_issue && rd_we) begin
        m_last[rd_addr]  = now;
        m_valid[rd_addr] = 1'b1;
        m_ld[rd_addr]    = rd_is_load;
      end
      if (e_stall && m_sc < 65535) m_sc++;
    end
    now++;
    #1;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned exp_sc;
    rst = 1'b0; enable = 1'b0; flush = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    s_rst = 1'b0; s_enable = 1'b0; s_dv = 1'b0; s_rd_we = 1'b0; s_ld = 1'b0;
    s_rs1 = '0; s_rs2 = '0; s_rd = '0;
    m_clear();
    now = 0; m_sc = 0;
    #2;
    check("rst_busy", 32'(busy_mask), 32'd0);
    check("rst_issue", 32'(issue), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; s_rst = 1'b1; enable = 1'b1;

    // RAW interlock: producer r3, consumer reads r3
    set_instr(1, 0, 0, 0, 0, 3, 1, 0); step();
    set_instr(1, 3, 1, 0, 0, 0, 0, 0); repeat (WB_LAT + 1) step();
    check("raw_stall_cnt", 32'(stall_cnt), 32'(RAW_STALLS));

    // ALU producer r2 then consumer; load producer r4 then consumer
    set_instr(1, 0, 0, 0, 0, 2, 1, 0); step();
    set_instr(1, 2, 1, 0, 0, 0, 0, 0); repeat (WB_LAT + 1) step();
    set_instr(1, 0, 0, 0, 0, 4, 1, 1); step();
    set_instr(1, 0, 0, 4, 1, 0, 0, 0); repeat (WB_LAT + 1) step();

    // Flush while stalled on r6 (load producer stalls in both builds)
    set_instr(1, 0, 0, 0, 0, 6, 1, 1); step();
    set_instr(1, 6, 1, 0, 0, 0, 0, 0); step();
    flush = 1'b1; step();
    flush = 1'b0; step();
    check("flush_busy", 32'(busy_mask), 32'd0);

    // Unused source ignored; back-to-back writes to r7 reload the countdown
    set_instr(1, 0, 0, 0, 0, 1, 1, 0); step();
    set_instr(1, 0, 0, 1, 0, 0, 0, 0); step();
    set_instr(1, 0, 0, 0, 0, 7, 1, 0); step(); step();
    set_instr(1, 7, 1, 0, 0, 0, 0, 0); repeat (WB_LAT + 1) step();

    // Enable low: nothing issues or stalls, counters drain
    set_instr(1, 0, 0, 0, 0, 0, 1, 1); step();
    enable = 1'b0;
    set_instr(1, 0, 1, 0, 0, 0, 0, 0); repeat (WB_LAT + 1) step();
    enable = 1'b1;

    // Reset mid-run with r5 pending
    set_instr(1, 0, 0, 0, 0, 5, 1, 0); step();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0); step();
    rst = 1'b0; set_instr(1, 5, 1, 0, 0, 0, 0, 0); step(); step();
    rst = 1'b1; step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      set_instr($urandom_range(3) != 0, $urandom_range(NREGS - 1), $urandom_range(1),
                $urandom_range(NREGS - 1), $urandom_range(1), $urandom_range(NREGS - 1),
                $urandom_range(1), $urandom_range(1));
      flush  = ($urandom_range(15) == 0);
      enable = ($urandom_range(7) != 0);
      rst    = ($urandom_range(63) != 0);
      step();
    end
    rst = 1'b1; flush = 1'b0; enable = 1'b1;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);

    // Saturation: self-dependent load r1 -> r1 on the long-latency instance
    s_enable = 1'b1; s_dv = 1'b1; s_rs1 = AW'(1); s_rd = AW'(1); s_rd_we = 1'b1; s_ld = 1'b1;
    repeat (16000) @(posedge clk);
    #1;
`ifdef SCB_FORWARD_EN
    exp_sc = 16000 / 2;
`else
    exp_sc = 16000 - (16000 + SAT_LAT) / (SAT_LAT + 1);
`endif
    check("sat_mid_cnt", 32'(s_stall_cnt), exp_sc);
    @(negedge clk);
    @(posedge clk);
    repeat (70000 - 16000 - 1) @(posedge clk);
    #1;
`ifdef SCB_FORWARD_EN
    exp_sc = 70000 / 2;
`else
    exp_sc = 70000 - (70000 + SAT_LAT) / (SAT_LAT + 1);
`endif
    if (exp_sc > 65535) exp_sc = 65535;
    check("sat_cnt", 32'(s_stall_cnt), exp_sc);

    s_enable = 1'b0;
    #1;
    check("sat_en_stall", 32'(s_stall), 32'd0);
    check("sat_en_issue", 32'(s_issue), 32'd0);
    repeat (SAT_LAT) @(posedge clk);
    #1;
    check("sat_drain_busy", 32'(s_busy), 32'd0);
    check("sat_hold_cnt", 32'(s_stall_cnt), exp_sc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
